// File: rtl/wbreg_bank.sv
// wbreg_bank - Wishbone-classic slave register bank.
//
// Provides NREGS read/write control registers with byte-lane write enables,
// a read-only status word, an interrupt pending (write-1-to-clear) / enable
// pair, programmable ack wait states and an error termination for unmapped
// word indices.
//
// Word map (w = wb_adr_i[AW-1:2]):
//   w <  NREGS      control register w (RW)
//   w == NREGS      status (RO, sampled from sts_i; writes acked and dropped)
//   w == NREGS+1    irq pending (read value, write-1-to-clear)
//   w == NREGS+2    irq enable (RW)
//   otherwise       error termination
//
// Ports:
//   wb_clk_i        clock
//   arst_i          asynchronous reset, active-low
//   wb_rst_i        synchronous reset, active-high
//   wb_adr_i        byte address, bits [1:0] ignored
//   wb_dat_i/o      write / read data (read data valid while wb_ack_o)
//   wb_sel_i        byte-lane select for writes
//   wb_we_i, wb_stb_i, wb_cyc_i   bus request
//   wb_ack_o        normal termination pulse
//   wb_err_o        error termination pulse
//   ctrl_o          control registers, reg k at [k*DW +: DW]
//   sts_i           status word
//   irq_ev_i        per-bit event pulses that set pending bits
//   irq_o           registered OR of (pending & enable)
//
// state    | meaning
// IDLE     | no transfer in progress, waiting for cyc&stb
// WAITING  | request seen, burning WAIT wait cycles
// RESP     | ack or err driven for one cycle, write commits at end

module wbreg_bank #(
  parameter int              NREGS   = 8,
  parameter int              DW      = 32,
  parameter int              AW      = 6,
  parameter int              WAIT    = 0,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic                wb_clk_i,
  input  logic                arst_i,
  input  logic                wb_rst_i,
  input  logic [AW-1:0]       wb_adr_i,
  input  logic [DW-1:0]       wb_dat_i,
  output logic [DW-1:0]       wb_dat_o,
  input  logic [DW/8-1:0]     wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [NREGS*DW-1:0] ctrl_o,
  input  logic [DW-1:0]       sts_i,
  input  logic [DW-1:0]       irq_ev_i,
  output logic                irq_o
);

  localparam int              WI      = AW - 2;
  localparam int              NB      = DW / 8;
  localparam logic [WI-1:0]   IDX_STS = WI'(NREGS);
  localparam logic [WI-1:0]   IDX_PND = WI'(NREGS + 1);
  localparam logic [WI-1:0]   IDX_EN  = WI'(NREGS + 2);
  localparam logic [2:0]      WAIT_M1 = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAITING = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                enter_resp;

  logic                req;
  logic [WI-1:0]       word;
  logic                hit_ctrl, hit_sts, hit_pend, hit_en, mapped;
  logic [DW-1:0]       lane_mask;
  logic [DW-1:0]       rd_data;
  logic [DW-1:0]       w1c_mask;
  logic                wr_commit;

  logic [NREGS*DW-1:0] ctrl_q;
  logic [DW-1:0]       pend_q, en_q, dat_q;
  logic                ack_q, err_q, irq_q;

  // Byte-offset bits are not part of the word decode.
  logic [1:0]          unused_adr;
  assign unused_adr = wb_adr_i[1:0];

  assign req  = wb_cyc_i & wb_stb_i;
  assign word = wb_adr_i[AW-1:2];

  assign hit_ctrl = (word < IDX_STS);
  assign hit_sts  = (word == IDX_STS);
  assign hit_pend = (word == IDX_PND);
  assign hit_en   = (word == IDX_EN);
  assign mapped   = hit_ctrl | hit_sts | hit_pend | hit_en;

  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < NB; b++) begin
      lane_mask[b*8 +: 8] = {8{wb_sel_i[b]}};
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit_ctrl) begin
      for (int k = 0; k < NREGS; k++) begin
        if (word == WI'(k)) rd_data = ctrl_q[k*DW +: DW];
      end
    end else if (hit_sts) begin
      rd_data = sts_i;
    end else if (hit_pend) begin
      rd_data = pend_q;
    end else if (hit_en) begin
      rd_data = en_q;
    end
  end

  // ack_q is only set for mapped words, so it doubles as the "mapped"
  // qualifier for the commit in RESP.
  assign wr_commit = (state_q == ST_RESP) & ack_q & wb_we_i;
  assign w1c_mask  = (wr_commit & hit_pend) ? (wb_dat_i & lane_mask) : '0;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAITING;
            cnt_d   = WAIT_M1;
          end
        end
      end
      ST_WAITING: begin
        // A master that withdraws mid-wait abandons the transfer silently.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
      ctrl_q <= {NREGS{RST_VAL}};
      pend_q <= '0;
      en_q   <= '0;
    end else if (wb_rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
      ctrl_q <= {NREGS{RST_VAL}};
      pend_q <= '0;
      en_q   <= '0;
    end else begin
      ack_q <= enter_resp & mapped;
      err_q <= enter_resp & ~mapped;
      if (enter_resp) dat_q <= rd_data;
      // Events are OR-ed in after the clear so a coincident event wins.
      pend_q <= (pend_q & ~w1c_mask) | irq_ev_i;
      irq_q  <= |(pend_q & en_q);
      if (wr_commit && hit_en) begin
        en_q <= (en_q & ~lane_mask) | (wb_dat_i & lane_mask);
      end
      for (int k = 0; k < NREGS; k++) begin
        if (wr_commit && hit_ctrl && (word == WI'(k))) begin
          ctrl_q[k*DW +: DW] <= (ctrl_q[k*DW +: DW] & ~lane_mask) |
                                (wb_dat_i & lane_mask);
        end
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign ctrl_o   = ctrl_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wbreg_bank.sv
// tb_wbreg_bank - self-checking bench for wbreg_bank.
//
// Two instances share one bus: dut0 with WAIT=0 and dut3 with WAIT=3;
// tsel routes wb_cyc_i to one of them. A per-instance reference model
// (plain arrays of register values) predicts read data, termination kind,
// latency, control outputs and irq_o. Directed table vectors, hand-written
// multi-cycle sequences and a randomized phase all compare against it.

module tb_wbreg_bank;

  localparam int NREGS = 8;

  logic        clk = 1'b0;
  logic        arst_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic [5:0]  adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic [31:0] sts = '0;
  logic [31:0] ev = '0;
  logic        tsel = 1'b0;

  logic        cyc0, cyc3;
  logic [31:0] dat0, dat3, dat_m;
  logic        ack0, ack3, err0, err3, irq0, irq3, ack_m, err_m;
  logic [255:0] ctrl0, ctrl3;

  assign cyc0  = cyc & ~tsel;
  assign cyc3  = cyc & tsel;
  assign ack_m = tsel ? ack3 : ack0;
  assign err_m = tsel ? err3 : err0;
  assign dat_m = tsel ? dat3 : dat0;

  always #5 clk = ~clk;

  wbreg_bank #(.NREGS(NREGS), .DW(32), .AW(6), .WAIT(0), .RST_VAL(32'h0)) dut0 (
    .wb_clk_i(clk), .arst_i(arst_i), .wb_rst_i(wb_rst_i),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat0), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc0),
    .wb_ack_o(ack0), .wb_err_o(err0), .ctrl_o(ctrl0),
    .sts_i(sts), .irq_ev_i(ev), .irq_o(irq0)
  );

  wbreg_bank #(.NREGS(NREGS), .DW(32), .AW(6), .WAIT(3), .RST_VAL(32'h0)) dut3 (
    .wb_clk_i(clk), .arst_i(arst_i), .wb_rst_i(wb_rst_i),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(dat3), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc3),
    .wb_ack_o(ack3), .wb_err_o(err3), .ctrl_o(ctrl3),
    .sts_i(sts), .irq_ev_i(ev), .irq_o(irq3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_ctrl [2][NREGS];
  logic [31:0] m_pend [2];
  logic [31:0] m_en   [2];

  typedef struct {
    bit          we;
    logic [3:0]  word;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] sts;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) r = r | (32'hFF << (8 * b));
    return r;
  endfunction

  function automatic bit irq_exp(input int d);
    return (m_pend[d] & m_en[d]) != 32'h0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NREGS; k++) m_ctrl[d][k] = 32'h0;
      m_pend[d] = 32'h0;
      m_en[d]   = 32'h0;
    end
  endtask

  task automatic chk_ctrl();
    for (int k = 0; k < NREGS; k++) begin
      chk($sformatf("ctrl0[%0d]", k), ctrl0[k*32 +: 32], m_ctrl[0][k]);
      chk($sformatf("ctrl3[%0d]", k), ctrl3[k*32 +: 32], m_ctrl[1][k]);
    end
  endtask

  task automatic chk_irq();
    chk("irq0", {31'h0, irq0}, {31'h0, irq_exp(0)});
    chk("irq3", {31'h0, irq3}, {31'h0, irq_exp(1)});
  endtask

  // One complete transfer on instance d. ev_resp is driven during the
  // termination cycle so it lands on the same edge as the write commit.
  task automatic bus(input bit d, input bit w, input logic [3:0] wi, input logic [1:0] lo,
                     input logic [31:0] dt, input logic [3:0] s, input logic [31:0] ev_resp,
                     output logic [31:0] rd, output bit got_ack, output bit got_err);
    int lat;
    int di;
    bit mapped;
    logic [31:0] exp_rd, m, w1c;
    di = d ? 1 : 0;
    mapped = (wi <= 4'd10);
    if (wi < 4'd8)       exp_rd = m_ctrl[di][wi];
    else if (wi == 4'd8) exp_rd = sts;
    else if (wi == 4'd9) exp_rd = m_pend[di];
    else if (wi == 4'd10) exp_rd = m_en[di];
    else                 exp_rd = 32'h0;

    @(negedge clk);
    tsel = d; adr = {wi, lo}; dat = dt; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0;
    while (lat < 20 && !got_ack && !got_err) begin
      @(posedge clk); #1;
      lat++;
      got_ack = ack_m;
      got_err = err_m;
    end
    rd = dat_m;
    chk("latency", lat, d ? 32'd4 : 32'd1);
    chk("ack", {31'h0, got_ack}, {31'h0, mapped});
    chk("err", {31'h0, got_err}, {31'h0, !mapped});
    chk("rd_data", rd, exp_rd);

    ev = ev_resp;
    @(posedge clk); #1;
    ev = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_pulse", {31'h0, ack_m}, 32'h0);
    chk("err_pulse", {31'h0, err_m}, 32'h0);

    m = lanes(s);
    w1c = 32'h0;
    if (mapped && w) begin
      if (wi < 4'd8)        m_ctrl[di][wi] = (m_ctrl[di][wi] & ~m) | (dt & m);
      else if (wi == 4'd10) m_en[di] = (m_en[di] & ~m) | (dt & m);
      else if (wi == 4'd9)  w1c = dt & m;
    end
    for (int dd = 0; dd < 2; dd++) begin
      m_pend[dd] = (m_pend[dd] & ~((dd == di) ? w1c : 32'h0)) | ev_resp;
    end

    @(posedge clk); #1;
    chk_irq();
    chk_ctrl();
  endtask

  task automatic pulse_ev(input logic [31:0] v);
    bit old0, old3;
    old0 = irq_exp(0);
    old3 = irq_exp(1);
    @(negedge clk);
    ev = v;
    @(negedge clk);
    ev = '0;
    chk("irq0_pre", {31'h0, irq0}, {31'h0, old0});
    chk("irq3_pre", {31'h0, irq3}, {31'h0, old3});
    for (int dd = 0; dd < 2; dd++) m_pend[dd] = m_pend[dd] | v;
    @(negedge clk);
    chk_irq();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bit ga, ge, seen;

    tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'b0101, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, 4'd3,  32'h0,        4'b1111, 32'h0,        1'b0, 32'h00AD00EF};
    tbl[2]  = '{1'b1, 4'd0,  32'h11223344, 4'b1111, 32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b0, 4'd0,  32'h0,        4'b1111, 32'h0,        1'b0, 32'h11223344};
    tbl[4]  = '{1'b1, 4'd8,  32'hFFFFFFFF, 4'b1111, 32'h0BADF00D, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 4'd8,  32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
    tbl[6]  = '{1'b0, 4'd12, 32'h0,        4'b1111, 32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b1, 4'd12, 32'h12345678, 4'b1111, 32'h0,        1'b1, 32'h0};
    tbl[8]  = '{1'b0, 4'd15, 32'h0,        4'b1111, 32'h0,        1'b1, 32'h0};
    tbl[9]  = '{1'b1, 4'd10, 32'h00000001, 4'b0001, 32'h0,        1'b0, 32'h0};
    tbl[10] = '{1'b0, 4'd10, 32'h0,        4'b1111, 32'h0,        1'b0, 32'h00000001};
    tbl[11] = '{1'b1, 4'd7,  32'hAABBCCDD, 4'b1000, 32'h0,        1'b0, 32'h0};
    tbl[12] = '{1'b0, 4'd7,  32'h0,        4'b1111, 32'h0,        1'b0, 32'hAA000000};
    tbl[13] = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 32'h0};
    tbl[14] = '{1'b0, 4'd3,  32'h0,        4'b1111, 32'h0,        1'b0, 32'h00AD00EF};

    model_reset();

    // Power-on reset held for three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_i = 1'b1;
    chk_ctrl();
    chk("rst_ack0", {31'h0, ack0}, 32'h0);
    chk("rst_err3", {31'h0, err3}, 32'h0);
    chk_irq();
    bus(1'b0, 1'b0, 4'd10, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("rst_en_read", rd, 32'h0);

    // Directed vectors on the zero-wait instance.
    for (int i = 0; i < 15; i++) begin
      sts = tbl[i].sts;
      bus(1'b0, tbl[i].we, tbl[i].word, 2'd0, tbl[i].dat, tbl[i].sel, 32'h0, rd, ga, ge);
      chk($sformatf("tbl%0d_err", i), {31'h0, ge}, {31'h0, tbl[i].exp_err});
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
    end
    chk("ctrl0_word3", ctrl0[127:96], 32'h00AD00EF);

    // Interrupt pending / enable behaviour (dut0 enable = 0x1).
    pulse_ev(32'h5);
    chk("irq0_set", {31'h0, irq0}, 32'h1);
    bus(1'b0, 1'b0, 4'd9, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("pend_after_ev", rd, 32'h5);
    bus(1'b0, 1'b1, 4'd9, 2'd0, 32'h1, 4'hF, 32'h0, rd, ga, ge);
    chk("irq0_after_w1c", {31'h0, irq0}, 32'h0);
    bus(1'b0, 1'b0, 4'd9, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("pend_after_w1c", rd, 32'h4);
    bus(1'b0, 1'b1, 4'd9, 2'd0, 32'h4, 4'hF, 32'h4, rd, ga, ge);
    bus(1'b0, 1'b0, 4'd9, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("pend_set_wins", rd, 32'h4);

    // Wait-state instance: status read with 4-cycle latency.
    sts = 32'h12345678;
    bus(1'b1, 1'b0, 4'd8, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("w3_sts_read", rd, 32'h12345678);

    // Strobe withdrawn during the wait: no termination, no write.
    @(negedge clk);
    tsel = 1'b1; adr = {4'd5, 2'd0}; dat = 32'h55555555; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack3 || err3) seen = 1'b1;
    end
    cyc = 1'b0; we = 1'b0;
    chk("abort_no_term", {31'h0, seen}, 32'h0);
    chk_ctrl();
    bus(1'b1, 1'b0, 4'd5, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("abort_no_write", rd, 32'h0);

    // Asynchronous reset in the middle of a waiting transfer.
    @(negedge clk);
    tsel = 1'b1; adr = {4'd6, 2'd0}; dat = 32'h66666666; sel = 4'hF; we = 1'b1;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    arst_i = 1'b0;
    #1;
    chk("async_rst_ctrl0_3", ctrl0[127:96], 32'h0);
    chk("async_rst_ack3", {31'h0, ack3}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    arst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ack3 || err3 || ack0 || err0) seen = 1'b1;
    end
    chk("rst_mid_no_term", {31'h0, seen}, 32'h0);
    chk_ctrl();
    bus(1'b1, 1'b0, 4'd6, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("rst_mid_target", rd, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      bit d, w;
      logic [3:0] wi;
      logic [31:0] evr;
      d  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wi = 4'($urandom_range(0, 15));
      sts = $urandom;
      evr = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_00FF) : 32'h0;
      bus(d, w, wi, 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
          evr, rd, ga, ge);
      if ($urandom_range(0, 4) == 0) pulse_ev($urandom & 32'h0000_0F0F);
    end

    // Synchronous reset clears everything at the clock edge.
    bus(1'b0, 1'b1, 4'd1, 2'd0, 32'hA5A5A5A5, 4'hF, 32'h0, rd, ga, ge);
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    model_reset();
    chk_ctrl();
    chk("sync_rst_irq0", {31'h0, irq0}, 32'h0);
    bus(1'b0, 1'b0, 4'd10, 2'd0, 32'h0, 4'hF, 32'h0, rd, ga, ge);
    chk("sync_rst_en", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbreg_bank.md
Name: wbreg_bank

Overview:
Parametrised Wishbone-classic slave register bank, successor to the fixed three-register demo block. Provides NREGS read/write control registers with byte-lane write enables and a read-only status word. Adds an interrupt pending/enable pair with write-1-to-clear semantics, programmable ack wait states, and an error response for unmapped addresses. Sits on the PicoRV32 Wishbone peripheral bus and feeds control words to, and collects status/events from, a peripheral core.

Parameters:
NREGS, 8, number of RW control registers (1..16)
DW, 32, data width, multiple of 8
AW, 6, byte-address width; word index = wb_adr_i[AW-1:2]; NREGS+3 <= 2^(AW-2) required
WAIT, 0, extra wait cycles between request and ack (0..7)
RST_VAL, 0, reset value of every control register

Ports:
wb_clk_i  in  1  master clock
arst_i  in  1  asynchronous reset, active-low
wb_rst_i  in  1  synchronous reset, active-high; same effect as arst_i
wb_adr_i  in  AW  byte address; bits [1:0] ignored
wb_dat_i  in  DW  write data
wb_dat_o  out  DW  read data, valid while wb_ack_o=1
wb_sel_i  in  DW/8  byte-lane select for writes
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  valid bus cycle
wb_ack_o  out  1  normal termination, one-cycle pulse
wb_err_o  out  1  error termination, one-cycle pulse
ctrl_o  out  NREGS*DW  control registers concatenated; reg k at [k*DW +: DW]
sts_i  in  DW  status word, sampled on read
irq_ev_i  in  DW  per-bit event pulses; set pending bits
irq_o  out  1  registered OR of (pending & enable)

Behaviour:
- Reset (arst_i=0 async, or wb_rst_i=1 at clock edge): state IDLE; ack, err, dat_o, irq_o = 0; ctrl regs = RST_VAL; pending = 0; enable = 0.
- Map (word index w): w<NREGS ctrl[w] RW; w=NREGS status RO (writes ignored, acked); w=NREGS+1 pending (reads value, writes are W1C); w=NREGS+2 enable RW; all other indices -> err.
- FSM: IDLE -> on cyc&stb: if WAIT=0 go RESP, else go WAITING with counter=WAIT-1.
- WAITING: counter decrements each cycle; at 0 go RESP. If cyc or stb drops -> IDLE; no write, no termination.
- RESP: exactly one of ack/err high for this one cycle. Write commits at the RESP edge, using the address, data, sel and we sampled in that cycle. dat_o is loaded on the edge entering RESP. Then go IDLE.
- Latency: termination appears WAIT+1 cycles after the request is first seen in IDLE. Back-to-back requests need at least one IDLE cycle, so WAIT=0 allows one transfer every 2 cycles.
- Byte lanes: only lanes with wb_sel_i[b]=1 are written (ctrl, enable, and W1C mask for pending). wb_sel_i=0 writes nothing but is still acked.
- Unmapped access: err pulse, no state change, dat_o=0.
- Pending update each cycle: pend <= (pend & ~w1c_mask) | irq_ev_i. A simultaneous event and clear on the same bit leaves it set (set wins).
- irq_o <= |(pend & en): one cycle after pending/enable change.
- dat_o holds its last value outside RESP. Masters must ignore it then.
- Reset mid-transfer: transfer is abandoned; no ack/err after reset deasserts.

Test Plan:
- Reset: arst_i=0 for 3 cycles, async mid-cycle -> ctrl_o all RST_VAL, ack/err/irq_o=0, read of enable=0.
- Write 0xDEADBEEF to word 3 with sel=4'b0101 over RST_VAL=0, then read word 3 -> 0x00AD00EF, ack pulses 1 cycle each, ctrl_o[127:96]=0x00AD00EF.
- WAIT=3: read status with sts_i=0x12345678 -> ack exactly 4 cycles after stb, dat_o=0x12345678. Drop stb after 2 cycles -> no ack, no write.
- IRQ: enable=0x1; pulse irq_ev_i=0x5 -> pending=0x5, irq_o=1 next cycle. W1C 0x1 -> pending=0x4, irq_o=0. W1C bit2 in the same cycle as an irq_ev_i bit2 pulse -> bit2 stays 1.
- Unmapped: access word 12 with NREGS=8 -> wb_err_o 1 cycle, no ack, no register change. Write to status -> ack, status read unchanged.
- Reset mid-transfer: assert arst_i during WAITING -> no ack after release, target register unchanged.
